// File: rtl/branch_predictor_btb_pkg.sv
// Shared encodings for the branch target buffer and its pattern history table.
package branch_predictor_btb_pkg;

  // EX-stage prediction outcome reported to the flush logic
  localparam logic [1:0] PS_MISS_NT = 2'd0;  // predicted not-taken, resolved taken
  localparam logic [1:0] PS_MISS_T  = 2'd1;  // predicted taken, resolved not-taken
  localparam logic [1:0] PS_HIT_NT  = 2'd2;  // correctly predicted not-taken
  localparam logic [1:0] PS_HIT_T   = 2'd3;  // correctly predicted taken

  // 2-bit saturating direction counter values
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;
  localparam logic [1:0] CNT_RESET = WNT;

  // Kind of control-flow instruction that allocated a BTB entry
  typedef enum logic {
    BTB_BRANCH = 1'b0,
    BTB_JUMP   = 1'b1
  } btb_type_e;

endpackage

// File: rtl/branch_predictor_btb_sat_counter2.sv
// 2-bit saturating up/down counter step used to train one PHT entry.
module sat_counter2
  import branch_predictor_btb_pkg::*;
(
  input  logic [1:0] count,
  input  logic       inc,
  output logic [1:0] count_next
);

  // Step toward strongly-taken on inc, toward strongly-not-taken otherwise, clamping at the ends
  always_comb begin
    count_next = count;
    if (inc) begin
      if (count != ST) count_next = count + 2'd1;
    end else begin
      if (count != SNT) count_next = count - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB plus 2-bit PHT: zero-latency IF/ID lookup, trained from resolved EX control flow.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int BTB_INDEX_BITS = 6,
  parameter int PHT_INDEX_BITS = 8,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] IF_pc,
  output logic            BTBhit,
  output logic            IF_Branch,
  output logic            IF_Jump,
  output logic [XLEN-1:0] IF_pc_imm,
  output logic [1:0]      IF_branch_prediction,
  input  logic [XLEN-1:0] ID_pc,
  output logic [1:0]      ID_branch_prediction,
  input  logic            EX_valid,
  input  logic [XLEN-1:0] EX_pc,
  input  logic            EX_Branch,
  input  logic            EX_Jump,
  input  logic            EX_ALUSrc,
  input  logic            EX_taken,
  input  logic [XLEN-1:0] EX_pc_imm,
  input  logic [1:0]      EX_branch_prediction,
  output logic [1:0]      prediction_status
);

  localparam int BTB_ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;
  localparam int TAG_W       = XLEN - BTB_INDEX_BITS - 2;

  logic              btb_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag    [BTB_ENTRIES];
  btb_type_e         btb_type   [BTB_ENTRIES];
  logic [XLEN-1:0]   btb_target [BTB_ENTRIES];
  logic [1:0]        pht        [PHT_ENTRIES];

  logic [BTB_INDEX_BITS-1:0] if_btb_idx;
  logic [TAG_W-1:0]          if_tag;
  logic [PHT_INDEX_BITS-1:0] if_pht_idx;
  logic [PHT_INDEX_BITS-1:0] id_pht_idx;
  logic [BTB_INDEX_BITS-1:0] ex_btb_idx;
  logic [TAG_W-1:0]          ex_tag;
  logic [PHT_INDEX_BITS-1:0] ex_pht_idx;

  logic       pred_taken;
  logic       pht_we;
  logic       btb_we;
  btb_type_e  btb_wtype;
  logic [1:0] pht_next;
  logic       unused_pc_bits;

  assign if_btb_idx = IF_pc[BTB_INDEX_BITS+1:2];
  assign if_tag     = IF_pc[XLEN-1:BTB_INDEX_BITS+2];
  assign if_pht_idx = IF_pc[PHT_INDEX_BITS+1:2];
  assign id_pht_idx = ID_pc[PHT_INDEX_BITS+1:2];
  assign ex_btb_idx = EX_pc[BTB_INDEX_BITS+1:2];
  assign ex_tag     = EX_pc[XLEN-1:BTB_INDEX_BITS+2];
  assign ex_pht_idx = EX_pc[PHT_INDEX_BITS+1:2];

  // Instruction-alignment bits and the PC bits above the ID PHT index carry no information here
  assign unused_pc_bits = ^{IF_pc[1:0], ID_pc[1:0], ID_pc[XLEN-1:PHT_INDEX_BITS+2],
                            EX_pc[1:0], EX_branch_prediction[0]};

  // Fetch-side lookup straight off the arrays; entry fields are masked on a miss
  always_comb begin
    BTBhit    = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
    IF_Branch = BTBhit && (btb_type[if_btb_idx] == BTB_BRANCH);
    IF_Jump   = BTBhit && (btb_type[if_btb_idx] == BTB_JUMP);
    IF_pc_imm = BTBhit ? btb_target[if_btb_idx] : '0;
  end

  assign IF_branch_prediction = pht[if_pht_idx];
  assign ID_branch_prediction = pht[id_pht_idx];

  // Compare the direction carried down the pipe with the resolved outcome; non-branches report no flush
  assign pred_taken = EX_branch_prediction[1];
  always_comb begin
    prediction_status = PS_HIT_NT;
    if (EX_Branch) begin
      case ({pred_taken, EX_taken})
        2'b00:   prediction_status = PS_HIT_NT;
        2'b01:   prediction_status = PS_MISS_NT;
        2'b10:   prediction_status = PS_MISS_T;
        default: prediction_status = PS_HIT_T;
      endcase
    end
  end

  // Branches train the PHT and allocate only when taken; JAL allocates; JALR never touches state
  always_comb begin
    pht_we    = EX_valid && EX_Branch;
    btb_we    = EX_valid && ((EX_Branch && EX_taken) || (!EX_Branch && EX_Jump && !EX_ALUSrc));
    btb_wtype = EX_Branch ? BTB_BRANCH : BTB_JUMP;
  end

  sat_counter2 u_pht_step (
    .count      (pht[ex_pht_idx]),
    .inc        (EX_taken),
    .count_next (pht_next)
  );

  // Array state: async clear, then at most one BTB write and one PHT write per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_tag[i]    <= '0;
        btb_type[i]   <= BTB_BRANCH;
        btb_target[i] <= '0;
      end
      for (int j = 0; j < PHT_ENTRIES; j++) begin
        pht[j] <= CNT_RESET;
      end
    end else begin
      if (pht_we) pht[ex_pht_idx] <= pht_next;
      if (btb_we) begin
        btb_valid[ex_btb_idx]  <= 1'b1;
        btb_tag[ex_btb_idx]    <= ex_tag;
        btb_type[ex_btb_idx]   <= btb_wtype;
        btb_target[ex_btb_idx] <= EX_pc_imm;
      end
    end
  end

  // A branch and a jump resolving in the same slot is an upstream decode error
  assert property (@(posedge clk) disable iff (!rst_n) !(EX_valid && EX_Branch && EX_Jump));

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

  logic        clk;
  logic        rst_n;
  logic [31:0] IF_pc;
  logic        BTBhit;
  logic        IF_Branch;
  logic        IF_Jump;
  logic [31:0] IF_pc_imm;
  logic [1:0]  IF_branch_prediction;
  logic [31:0] ID_pc;
  logic [1:0]  ID_branch_prediction;
  logic        EX_valid;
  logic [31:0] EX_pc;
  logic        EX_Branch;
  logic        EX_Jump;
  logic        EX_ALUSrc;
  logic        EX_taken;
  logic [31:0] EX_pc_imm;
  logic [1:0]  EX_branch_prediction;
  logic [1:0]  prediction_status;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 0;

  branch_predictor_btb #(.BTB_INDEX_BITS(6), .PHT_INDEX_BITS(8), .XLEN(32)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .IF_pc                (IF_pc),
    .BTBhit               (BTBhit),
    .IF_Branch            (IF_Branch),
    .IF_Jump              (IF_Jump),
    .IF_pc_imm            (IF_pc_imm),
    .IF_branch_prediction (IF_branch_prediction),
    .ID_pc                (ID_pc),
    .ID_branch_prediction (ID_branch_prediction),
    .EX_valid             (EX_valid),
    .EX_pc                (EX_pc),
    .EX_Branch            (EX_Branch),
    .EX_Jump              (EX_Jump),
    .EX_ALUSrc            (EX_ALUSrc),
    .EX_taken             (EX_taken),
    .EX_pc_imm            (EX_pc_imm),
    .EX_branch_prediction (EX_branch_prediction),
    .prediction_status    (prediction_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model: entries keyed by owning PC ----------------
  bit          m_valid  [64];
  logic [31:0] m_owner  [64];
  bit          m_jump   [64];
  logic [31:0] m_target [64];
  int          m_pht    [256];

  function automatic int bidx(input logic [31:0] pc); return int'((pc >> 2) % 64);  endfunction
  function automatic int pidx(input logic [31:0] pc); return int'((pc >> 2) % 256); endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int p, b;
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        m_valid[i] = 0; m_owner[i] = 0; m_jump[i] = 0; m_target[i] = 0;
      end
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
    end else if (EX_valid) begin
      p = pidx(EX_pc);
      b = bidx(EX_pc);
      if (EX_Branch) begin
        if (EX_taken) m_pht[p] = (m_pht[p] < 3) ? m_pht[p] + 1 : 3;
        else          m_pht[p] = (m_pht[p] > 0) ? m_pht[p] - 1 : 0;
        if (EX_taken) begin
          m_valid[b] = 1; m_owner[b] = EX_pc; m_jump[b] = 0; m_target[b] = EX_pc_imm;
        end
      end else if (EX_Jump && !EX_ALUSrc) begin
        m_valid[b] = 1; m_owner[b] = EX_pc; m_jump[b] = 1; m_target[b] = EX_pc_imm;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin : compare
    int b;
    bit hit;
    logic [1:0] exp_ps;
    if (check_en && rst_n) begin
      b   = bidx(IF_pc);
      hit = m_valid[b] && ((m_owner[b] >> 2) == (IF_pc >> 2));
      check("m_btbhit",  {31'd0, BTBhit},    {31'd0, hit});
      check("m_if_br",   {31'd0, IF_Branch}, {31'd0, hit && !m_jump[b]});
      check("m_if_jump", {31'd0, IF_Jump},   {31'd0, hit && m_jump[b]});
      check("m_if_imm",  IF_pc_imm,          hit ? m_target[b] : 32'd0);
      check("m_if_pred", {30'd0, IF_branch_prediction}, 32'(m_pht[pidx(IF_pc)]));
      check("m_id_pred", {30'd0, ID_branch_prediction}, 32'(m_pht[pidx(ID_pc)]));
      if (EX_Branch) begin
        if (EX_branch_prediction[1] && EX_taken)        exp_ps = 2'd3;
        else if (!EX_branch_prediction[1] && !EX_taken) exp_ps = 2'd2;
        else if (EX_branch_prediction[1])               exp_ps = 2'd1;
        else                                            exp_ps = 2'd0;
        check("m_status", {30'd0, prediction_status}, {30'd0, exp_ps});
      end else begin
        check("m_status_nobr", {31'd0, prediction_status[1]}, 32'd1);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    EX_valid = 0; EX_Branch = 0; EX_Jump = 0; EX_ALUSrc = 0; EX_taken = 0;
    EX_pc = 0; EX_pc_imm = 0; EX_branch_prediction = 2'd1;
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic [1:0] pred);
    idle();
    EX_valid = 1; EX_Branch = 1; EX_pc = pc; EX_pc_imm = tgt;
    EX_taken = tk; EX_branch_prediction = pred;
  endtask

  task automatic drive_jump(input logic [31:0] pc, input logic [31:0] tgt, input logic jalr);
    idle();
    EX_valid = 1; EX_Jump = 1; EX_ALUSrc = jalr; EX_pc = pc; EX_pc_imm = tgt;
  endtask

  task automatic look(input logic [31:0] pc);
    IF_pc = pc; ID_pc = pc; #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [31:0] rst_pcs [3];
    int exp_up [3];
    int exp_dn [4];
    rst_pcs = '{32'h0, 32'h100, 32'hFFFC};
    exp_up  = '{3, 3, 3};
    exp_dn  = '{2, 1, 0, 0};

    rst_n = 0; idle(); IF_pc = 0; ID_pc = 0;
    repeat (2) @(posedge clk);
    #1;
    foreach (rst_pcs[i]) begin
      look(rst_pcs[i]);
      check("rst_btbhit",  {31'd0, BTBhit}, 32'd0);
      check("rst_imm",     IF_pc_imm, 32'd0);
      check("rst_if_pred", {30'd0, IF_branch_prediction}, 32'd1);
      check("rst_id_pred", {30'd0, ID_branch_prediction}, 32'd1);
    end

    // reset asserted while a taken-branch update is pending: nothing must land
    rst_n = 1;
    tick();
    check_en = 1;
    drive_branch(32'h80, 32'h99C, 1'b1, 2'd1);
    #2 rst_n = 0;
    @(posedge clk); #1;
    idle();
    #2 rst_n = 1;
    tick();
    look(32'h80);
    check("rst_upd_hit",  {31'd0, BTBhit}, 32'd0);
    check("rst_upd_pred", {30'd0, IF_branch_prediction}, 32'd1);

    // first taken branch at 0x40, predicted weakly not-taken
    drive_branch(32'h40, 32'h80, 1'b1, 2'd1);
    #1 check("st_miss_nt", {30'd0, prediction_status}, 32'd0);
    tick(); idle();
    look(32'h40);
    check("br_hit",    {31'd0, BTBhit},    32'd1);
    check("br_type",   {31'd0, IF_Branch}, 32'd1);
    check("br_imm",    IF_pc_imm,          32'h80);
    check("br_pred",   {30'd0, IF_branch_prediction}, 32'd2);

    foreach (exp_up[i]) begin
      drive_branch(32'h40, 32'h80, 1'b1, 2'd2);
      tick(); idle(); look(32'h40);
      check("pht_up", {30'd0, IF_branch_prediction}, 32'(exp_up[i]));
    end
    foreach (exp_dn[i]) begin
      drive_branch(32'h40, 32'h80, 1'b0, 2'd3);
      tick(); idle(); look(32'h40);
      check("pht_down", {30'd0, IF_branch_prediction}, 32'(exp_dn[i]));
    end
    check("nt_keep_hit", {31'd0, BTBhit}, 32'd1);
    check("nt_keep_imm", IF_pc_imm, 32'h80);

    // JAL allocates without touching the PHT; JALR at the same index does nothing
    drive_jump(32'h200, 32'h1000, 1'b0);
    tick(); idle(); look(32'h200);
    check("jal_hit",  {31'd0, BTBhit},    32'd1);
    check("jal_jump", {31'd0, IF_Jump},   32'd1);
    check("jal_br",   {31'd0, IF_Branch}, 32'd0);
    check("jal_imm",  IF_pc_imm,          32'h1000);
    check("jal_pht",  {30'd0, IF_branch_prediction}, 32'd1);
    drive_jump(32'h300, 32'h2000, 1'b1);
    tick(); idle(); look(32'h300);
    check("jalr_miss", {31'd0, BTBhit}, 32'd0);
    look(32'h200);
    check("jalr_keep", {31'd0, BTBhit}, 32'd1);

    // alias 0x140 onto 0x40's slot; no same-cycle bypass
    drive_branch(32'h140, 32'h500, 1'b1, 2'd1);
    look(32'h140);
    check("alias_nobyp", {31'd0, BTBhit}, 32'd0);
    tick(); idle(); look(32'h140);
    check("alias_hit", {31'd0, BTBhit}, 32'd1);
    check("alias_imm", IF_pc_imm, 32'h500);
    look(32'h40);
    check("alias_evict", {31'd0, BTBhit}, 32'd0);

    // EX_valid low blocks training; then a mispredicted-taken not-taken branch
    drive_branch(32'h80, 32'h300, 1'b1, 2'd1);
    EX_valid = 0;
    tick(); idle(); look(32'h80);
    check("inval_hit",  {31'd0, BTBhit}, 32'd0);
    check("inval_pred", {30'd0, IF_branch_prediction}, 32'd1);
    drive_branch(32'h80, 32'h300, 1'b0, 2'd3);
    #1 check("st_miss_t", {30'd0, prediction_status}, 32'd1);
    tick(); idle(); look(32'h80);
    check("nt_noalloc", {31'd0, BTBhit}, 32'd0);
    check("nt_pred",    {30'd0, IF_branch_prediction}, 32'd0);

    // mixed traffic over a small aliasing PC range, checked by the model each cycle
    for (int n = 0; n < 300; n++) begin
      int kind;
      idle();
      kind = int'($urandom_range(0, 3));
      EX_valid  = ($urandom_range(0, 3) != 0);
      EX_pc     = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
      EX_pc_imm = $urandom & 32'hFFFF_FFFC;
      EX_taken  = 1'($urandom_range(0, 1));
      EX_branch_prediction = 2'($urandom_range(0, 3));
      if (kind == 0) EX_Branch = 1;
      else if (kind == 1) EX_Jump = 1;
      else if (kind == 2) begin EX_Jump = 1; EX_ALUSrc = 1; end
      IF_pc = $urandom_range(0, 1023);
      ID_pc = $urandom_range(0, 1023);
      tick();
    end
    idle();
    tick();

    check_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
